// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from uart_receiver through a ready/clear handshake and
// buffers them in a first-word-fall-through FIFO with occupancy and sticky overrun status.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk_50mhz,
  input  logic                rst,
  input  logic                rx_data_ready,
  input  logic [7:0]          rx_data,
  output logic                rx_clear_ready,
  output logic [7:0]          m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DEPTH_LOG2:0] fifo_count,
  output logic                fifo_full,
  output logic                overrun,
  input  logic                overrun_clear
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   count_t;
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam count_t C_FULL = count_t'(DEPTH);

  state_t     r_state;
  state_t     w_stateNext;
  logic       w_capture;
  logic       r_clearReady;
  ptr_t       r_wrPtr;
  ptr_t       r_rdPtr;
  count_t     r_count;
  logic       r_overrun;
  logic [7:0] r_mem [DEPTH];

  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;

  // A byte is taken only on the IDLE->CLEAR transition, so a slow flag clear never double-writes.
  always_comb begin
    w_stateNext = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_data_ready) begin
          w_capture   = 1'b1;
          w_stateNext = CLEAR;
        end
      end
      CLEAR: begin
        if (!rx_data_ready) begin
          w_stateNext = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_state      <= IDLE;
      r_clearReady <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_clearReady <= (w_stateNext == CLEAR);
    end
  end

  assign w_full = (r_count == C_FULL);
  assign w_pop  = (r_count != '0) && m_ready;
  // A full FIFO still accepts a byte when the consumer frees a slot on the same edge.
  assign w_push = w_capture && (!w_full || w_pop);
  assign w_drop = w_capture && w_full && !w_pop;

  always_ff @(posedge clk_50mhz) begin
    if (w_push && !rst) begin
      r_mem[r_wrPtr] <= rx_data;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + ptr_t'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + ptr_t'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + count_t'(1);
        2'b01:   r_count <= r_count - count_t'(1);
        default: r_count <= r_count;
      endcase
      // A fresh drop outranks a simultaneous clear request.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clear) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rx_clear_ready = r_clearReady;
  assign m_data         = r_mem[r_rdPtr];
  assign m_valid        = (r_count != '0);
  assign fifo_count     = r_count;
  assign fifo_full      = w_full;
  assign overrun        = r_overrun;

endmodule
